// File: rtl/final_color_pipe_if.sv
// Palette download bus: one-clk write strobe with address/nibble, acknowledged the following clk.
interface final_color_pipe_if;
    localparam int unsigned DN_AW = 12;
    localparam int unsigned DN_DW = 4;

    logic             dn_wr;
    logic [DN_AW-1:0] dn_addr;
    logic [DN_DW-1:0] dn_data;
    logic             dn_ack;

    modport master (output dn_wr, output dn_addr, output dn_data, input  dn_ack);
    modport slave  (input  dn_wr, input  dn_addr, input  dn_data, output dn_ack);
endinterface

// File: rtl/final_color_pipe.sv
// Final video colour stage: layer select from the priority PAL outputs, palette lookup in a
// downloadable 1024x12 colour RAM, and blank-gated RGB aligned with delayed sync/blank.
module final_color_pipe #(
    parameter int unsigned      PAL_AW    = 10,
    parameter int unsigned      CW        = 4,
    parameter logic [3*CW-1:0]  BLANK_RGB = '0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           pix_ce,
    input  logic           LAYER_SELA,
    input  logic           LAYER_SELB,
    input  logic [2:0]     COLBANK,
    input  logic [6:0]     spr_pix,
    input  logic [6:0]     l2_pix,
    input  logic [6:0]     bg_pix,
    input  logic [2:0]     layer_en,
    input  logic           hblank_in,
    input  logic           vblank_in,
    input  logic           hs_in,
    input  logic           vs_in,
    final_color_pipe_if.slave dn,
    output logic [CW-1:0]  R,
    output logic [CW-1:0]  G,
    output logic [CW-1:0]  B,
    output logic           hblank_out,
    output logic           vblank_out,
    output logic           hs_out,
    output logic           vs_out
);
    localparam int unsigned RGB_W = 3 * CW;
    localparam int unsigned DEPTH = 1 << PAL_AW;
    localparam int unsigned CODE_W = 7;
    localparam int unsigned SB_W = 4;

    logic [RGB_W-1:0]  pal_ram [DEPTH];

    logic [CODE_W-1:0] spr_code_c;
    logic [CODE_W-1:0] l2_code_c;
    logic [CODE_W-1:0] bg_code_c;
    logic [CODE_W-1:0] sel_code_c;
    logic [PAL_AW-1:0] pal_addr_c;
    logic [PAL_AW-1:0] wr_addr_c;
    logic              ram_we_c;

    logic [PAL_AW-1:0] addr_s0;
    logic [SB_W-1:0]   sb_s0;
    logic [RGB_W-1:0]  rd_s1;
    logic [SB_W-1:0]   sb_s1;

    // Layer enables force disabled codes to 0 before the PAL-driven select.
    always_comb begin
        spr_code_c = layer_en[0] ? spr_pix : '0;
        l2_code_c  = layer_en[1] ? l2_pix  : '0;
        bg_code_c  = layer_en[2] ? bg_pix  : '0;
        sel_code_c = l2_code_c;
        case ({LAYER_SELB, LAYER_SELA})
            2'b11:   sel_code_c = bg_code_c;
            2'b10:   sel_code_c = spr_code_c;
            default: sel_code_c = l2_code_c;
        endcase
        pal_addr_c = PAL_AW'({COLBANK, sel_code_c});
    end

    assign wr_addr_c = PAL_AW'(dn.dn_addr[9:0]);
    assign ram_we_c  = dn.dn_wr && reset_n;

    // Single-port palette RAM, nibble-writable; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            case (dn.dn_addr[11:10])
                2'd0:    pal_ram[wr_addr_c][2*CW +: CW] <= CW'(dn.dn_data);
                2'd1:    pal_ram[wr_addr_c][CW +: CW]   <= CW'(dn.dn_data);
                2'd2:    pal_ram[wr_addr_c][0 +: CW]    <= CW'(dn.dn_data);
                default: ;
            endcase
        end
    end

    // Three pix_ce stages; a download owns the RAM port, so the stage-1 read holds on collision.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_s0    <= '0;
            sb_s0      <= '0;
            rd_s1      <= '0;
            sb_s1      <= '0;
            R          <= '0;
            G          <= '0;
            B          <= '0;
            hblank_out <= 1'b1;
            vblank_out <= 1'b1;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            dn.dn_ack  <= 1'b0;
        end else begin
            dn.dn_ack <= dn.dn_wr;
            if (pix_ce) begin
                addr_s0 <= pal_addr_c;
                sb_s0   <= {hblank_in, vblank_in, hs_in, vs_in};
                if (!dn.dn_wr) begin
                    rd_s1 <= pal_ram[addr_s0];
                end
                sb_s1 <= sb_s0;
                {R, G, B} <= (sb_s1[3] || sb_s1[2]) ? BLANK_RGB : rd_s1;
                {hblank_out, vblank_out, hs_out, vs_out} <= sb_s1;
            end
        end
    end
endmodule

// File: tb/tb_final_color_pipe.sv
// Scoreboard bench for final_color_pipe: a behavioural palette/pipeline model predicts every output.
module tb_final_color_pipe;
    typedef struct packed {
        logic [11:0] rgb;
        logic        hb;
        logic        vb;
        logic        hs;
        logic        vs;
    } exp_t;

    typedef struct packed {
        logic [9:0] addr;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       vs;
    } pend_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pix_ce;
    logic       sela;
    logic       selb;
    logic [2:0] colbank;
    logic [2:0] layer_en;
    logic [6:0] spr;
    logic [6:0] l2;
    logic [6:0] bg;
    logic       hbi;
    logic       vbi;
    logic       hsi;
    logic       vsi;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hbo;
    logic       vbo;
    logic       hso;
    logic       vso;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] mem [1024];
    exp_t        q[$];
    exp_t        cur;
    pend_t       pend;
    logic [11:0] last_rd;
    logic        exp_ack;
    logic        armed = 1'b0;

    always #5 clk = ~clk;

    final_color_pipe_if dn_bus();

    final_color_pipe dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_ce     (pix_ce),
        .LAYER_SELA (sela),
        .LAYER_SELB (selb),
        .COLBANK    (colbank),
        .spr_pix    (spr),
        .l2_pix     (l2),
        .bg_pix     (bg),
        .layer_en   (layer_en),
        .hblank_in  (hbi),
        .vblank_in  (vbi),
        .hs_in      (hsi),
        .vs_in      (vsi),
        .dn         (dn_bus),
        .R          (r),
        .G          (g),
        .B          (b),
        .hblank_out (hbo),
        .vblank_out (vbo),
        .hs_out     (hso),
        .vs_out     (vso)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic pend_t model_s0();
        logic [6:0] s;
        logic [6:0] l;
        logic [6:0] k;
        logic [6:0] c;
        pend_t      p;
        s = layer_en[0] ? spr : 7'h00;
        l = layer_en[1] ? l2  : 7'h00;
        k = layer_en[2] ? bg  : 7'h00;
        if (selb && sela)  c = k;
        else if (selb)     c = s;
        else               c = l;
        p.addr = {colbank, c};
        p.hb = hbi;
        p.vb = vbi;
        p.hs = hsi;
        p.vs = vsi;
        return p;
    endfunction

    // One clk: update the model at the edge, then compare all outputs 1 time unit later.
    task automatic tick();
        exp_t        e;
        logic [11:0] rd;
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
            q.push_back(exp_t'(0));
            pend    = pend_t'(0);
            last_rd = 12'h000;
            cur     = '{rgb: 12'h000, hb: 1'b1, vb: 1'b1, hs: 1'b0, vs: 1'b0};
            exp_ack = 1'b0;
            armed   = 1'b1;
        end else begin
            if (pix_ce) begin
                rd      = dn_bus.dn_wr ? last_rd : mem[pend.addr];
                last_rd = rd;
                e.rgb   = (pend.hb || pend.vb) ? 12'h000 : rd;
                e.hb    = pend.hb;
                e.vb    = pend.vb;
                e.hs    = pend.hs;
                e.vs    = pend.vs;
                if (q.size() > 0) cur = q.pop_front();
                q.push_back(e);
                pend = model_s0();
            end
            if (dn_bus.dn_wr) begin
                case (dn_bus.dn_addr[11:10])
                    2'd0:    mem[dn_bus.dn_addr[9:0]][11:8] = dn_bus.dn_data;
                    2'd1:    mem[dn_bus.dn_addr[9:0]][7:4]  = dn_bus.dn_data;
                    2'd2:    mem[dn_bus.dn_addr[9:0]][3:0]  = dn_bus.dn_data;
                    default: ;
                endcase
            end
            exp_ack = dn_bus.dn_wr;
        end
        #1;
        if (armed) begin
            check("dn_ack", 16'(dn_bus.dn_ack), 16'(exp_ack));
            check("rgb", 16'({r, g, b}), 16'(cur.rgb));
            check("sync_blank", 16'({hbo, vbo, hso, vso}), 16'({cur.hb, cur.vb, cur.hs, cur.vs}));
        end
    endtask

    task automatic run_ce(input int n);
        pix_ce = 1'b1;
        repeat (n) tick();
    endtask

    // Steady bg pixel for a full pipeline depth, then compare RGB against a hand-derived constant.
    task automatic readback(input string tag, input logic [2:0] bank, input logic [6:0] code,
                            input logic [11:0] exp);
        sela = 1'b1; selb = 1'b1; layer_en = 3'b111;
        colbank = bank; bg = code; hbi = 1'b0; vbi = 1'b0;
        run_ce(4);
        check(tag, 16'({r, g, b}), 16'(exp));
    endtask

    initial begin
        logic [9:0] e;
        reset_n = 1'b0; pix_ce = 1'b0; sela = 1'b0; selb = 1'b0;
        colbank = 3'd0; layer_en = 3'b111; spr = 7'h00; l2 = 7'h00; bg = 7'h00;
        hbi = 1'b0; vbi = 1'b0; hsi = 1'b0; vsi = 1'b0;
        dn_bus.dn_wr = 1'b0; dn_bus.dn_addr = 12'h000; dn_bus.dn_data = 4'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 12'h000;

        tick();
        tick();
        reset_n = 1'b1;

        // Ramp load, back-to-back writes with the pipeline stalled.
        for (int ch = 0; ch < 3; ch++) begin
            for (int i = 0; i < 1024; i++) begin
                e = 10'(i);
                dn_bus.dn_wr   = 1'b1;
                dn_bus.dn_addr = {2'(ch), e};
                dn_bus.dn_data = (ch == 0) ? e[3:0] : (ch == 1) ? e[7:4] : e[9:6];
                tick();
            end
        end
        dn_bus.dn_wr = 1'b0;
        tick();

        readback("entry_292", 3'b101, 7'h12, 12'h29A);

        // Layer select sweep.
        spr = 7'h05; l2 = 7'h0A; bg = 7'h0F; colbank = 3'd0;
        for (int s = 0; s < 4; s++) begin
            {selb, sela} = 2'(s);
            run_ce(1);
        end
        run_ce(3);

        // Layer enable forcing.
        layer_en = 3'b000; {selb, sela} = 2'b11; colbank = 3'd2;
        run_ce(2);
        layer_en = 3'b101; {selb, sela} = 2'b00;
        run_ce(4);
        layer_en = 3'b111;

        // Four-pixel hblank with hs over a varying line.
        {selb, sela} = 2'b11; colbank = 3'd1;
        for (int i = 0; i < 12; i++) begin
            bg  = 7'(i * 5 + 3);
            hbi = (i >= 4 && i < 8);
            hsi = (i >= 4 && i < 8);
            run_ce(1);
        end
        hbi = 1'b0; hsi = 1'b0;
        run_ce(3);

        // pix_ce low for 5 clk mid-line with inputs changing underneath.
        for (int i = 0; i < 6; i++) begin
            bg = 7'(i * 11 + 1);
            run_ce(1);
        end
        pix_ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bg = 7'($urandom_range(0, 127));
            vbi = i[0];
            tick();
        end
        vbi = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bg = 7'(i * 13 + 2);
            run_ce(1);
        end

        // Download colliding with stage-1 reads.
        for (int i = 0; i < 8; i++) begin
            bg = 7'(i * 9 + 1);
            colbank = 3'(i);
            dn_bus.dn_wr   = (i == 4);
            dn_bus.dn_addr = 12'h00F;
            dn_bus.dn_data = 4'h3;
            run_ce(1);
        end
        dn_bus.dn_wr = 1'b1; dn_bus.dn_addr = 12'hC10; dn_bus.dn_data = 4'h7;
        run_ce(1);
        dn_bus.dn_wr = 1'b0;
        run_ce(3);
        readback("collide_write", 3'd0, 7'h0F, 12'h300);
        readback("chan3_nowrite", 3'd0, 7'h10, 12'h010);

        // One-clk reset mid-frame with a write in flight.
        for (int i = 0; i < 5; i++) begin
            bg = 7'(i * 7 + 20);
            run_ce(1);
        end
        reset_n = 1'b0;
        dn_bus.dn_wr = 1'b1; dn_bus.dn_addr = 12'h00F; dn_bus.dn_data = 4'h9;
        tick();
        reset_n = 1'b1;
        dn_bus.dn_wr = 1'b0;
        run_ce(3);
        readback("reset_keeps_0F", 3'd0, 7'h0F, 12'h300);
        readback("reset_keeps_292", 3'b101, 7'h12, 12'h29A);

        // Random traffic: pix_ce, selects, blanks, syncs and downloads.
        for (int i = 0; i < 400; i++) begin
            pix_ce   = ($urandom_range(0, 3) != 0);
            {selb, sela} = 2'($urandom_range(0, 3));
            colbank  = 3'($urandom_range(0, 7));
            layer_en = 3'($urandom_range(0, 7));
            spr = 7'($urandom_range(0, 127));
            l2  = 7'($urandom_range(0, 127));
            bg  = 7'($urandom_range(0, 127));
            hbi = ($urandom_range(0, 7) == 0);
            vbi = ($urandom_range(0, 15) == 0);
            hsi = ($urandom_range(0, 3) == 0);
            vsi = ($urandom_range(0, 3) == 0);
            dn_bus.dn_wr   = ($urandom_range(0, 5) == 0);
            dn_bus.dn_addr = 12'($urandom_range(0, 4095));
            dn_bus.dn_data = 4'($urandom_range(0, 15));
            tick();
        end
        dn_bus.dn_wr = 1'b0;
        run_ce(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/final_color_pipe.md
Name: final_color_pipe

Overview:
- Sits directly downstream of the final-video priority PAL.
- Takes the PAL's LAYER_SELA/LAYER_SELB and COLBANK3..5 outputs together with the three candidate pixel codes (sprite, layer 2, background) and selects the winning pixel.
- Forms a 10-bit palette address and looks it up in an internal 1024x12 colour RAM, which is loaded from the three 1024x4 colour PROM images over the ROM download port.
- Emits registered, blank-gated RGB aligned with delayed sync and blank.

Parameters:
- PAL_AW, 10, palette address width (3 bank bits + 7 pixel bits).
- CW, 4, bits per colour channel.
- BLANK_RGB, 12'h000, value driven on RGB while blanked.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- pix_ce  in  1  pixel clock enable; the pipeline advances only when this is high
- LAYER_SELA  in  1  priority select A, from the priority PAL
- LAYER_SELB  in  1  priority select B, from the priority PAL
- COLBANK  in  3  {COLBANK5,COLBANK4,COLBANK3} from the priority PAL
- spr_pix  in  7  sprite line-buffer pixel code
- l2_pix  in  7  layer-2 pixel code
- bg_pix  in  7  background pixel code
- layer_en  in  3  debug enables {bg,l2,spr}; a disabled layer's code is forced to 0
- hblank_in  in  1  horizontal blank
- vblank_in  in  1  vertical blank
- hs_in  in  1  horizontal sync
- vs_in  in  1  vertical sync
- dn_wr  in  1  download write strobe, one clk wide
- dn_addr  in  12  download address: [11:10] = channel (0=R, 1=G, 2=B, 3=ignored), [9:0] = entry
- dn_data  in  4  download nibble
- dn_ack  out  1  one-clk pulse, the clk after a write commits
- R  out  4  red
- G  out  4  green
- B  out  4  blue
- hblank_out  out  1  delayed blank
- vblank_out  out  1  delayed blank
- hs_out  out  1  delayed sync
- vs_out  out  1  delayed sync

Behaviour:
- Reset (reset_n low at a clk edge): R/G/B = 0, hblank_out = vblank_out = 1, hs_out = vs_out = 0, dn_ack = 0, all pipeline registers cleared.
- Palette RAM contents are NOT cleared by reset.
- Layer select, by {LAYER_SELB,LAYER_SELA}:
  - 2'b11 -> bg_pix
  - 2'b10 -> spr_pix
  - 2'b01 and 2'b00 -> l2_pix
- Palette address = {COLBANK, selected_code[6:0]}.
- Stage 0 (pix_ce): register the palette address, blanks and syncs.
- Stage 1 (pix_ce): read the palette RAM at the stage-0 address; carry blanks and syncs forward.
- Stage 2 (pix_ce): register RGB; RGB = BLANK_RGB when the stage-1 hblank or vblank is high; syncs and blanks are output.
- Latency: exactly 3 pix_ce edges from input to RGB; syncs and blanks have the identical latency.
- pix_ce low: every register holds its value.
- Download:
  - On dn_wr, write dn_data into the nibble of entry dn_addr[9:0] selected by dn_addr[11:10]; the other nibbles of that entry are unchanged.
  - dn_addr[11:10] = 3: no write, but dn_ack still pulses.
  - dn_ack rises the clk after dn_wr.
  - A dn_wr that is still high on the following clk counts as a second write.
- Collision: when dn_wr and a stage-1 read occur on the same clk, the write takes the RAM port. The stage-1 read data holds its previous value for that pixel; the write is never dropped.
- Back-to-back downloads: one write per clk is sustained with no stall.
- Reset mid-download: a write in progress on the reset clk is discarded and dn_ack is not asserted.
- No arithmetic; address width is exactly PAL_AW; no wrap logic beyond natural truncation.

Test Plan:
- Load ramp via dn_wr (R=entry[3:0], G=entry[7:4], B=entry[9:6] truncated to 4 bits), then select bg with {B,A}=11, COLBANK=3'b101, bg_pix=7'h12 -> after 3 pix_ce, RGB = contents of entry 0x292; dn_ack seen once per write.
- {B,A} sweep 00/01/10/11 with spr=0x05, l2=0x0A, bg=0x0F, COLBANK=0 -> addresses 0x0A, 0x0A, 0x05, 0x0F respectively, in order with 3-cycle latency.
- hblank_in pulse of 4 pixels -> RGB=000 for exactly those 4 pixels, shifted by 3 pix_ce, with hblank_out aligned to them; hs_out delay identical.
- pix_ce held low for 5 clk mid-line -> outputs frozen; resuming yields no lost or duplicated pixels.
- dn_wr colliding with a pix_ce read -> the write lands (readback later correct) and the colliding pixel repeats the previous RGB; dn_addr[11:10]=3 -> RAM unchanged, dn_ack pulses.
- reset_n low mid-frame for 1 clk -> outputs go to reset values next clk and palette contents survive.
